// File: rtl/fifo_byte_serializer.sv
// fifo_byte_serializer
// Pops words from a 32-bit FIFO (rd/empty/data_out interface, one cycle read
// latency) and streams each word out as bytes on a valid/ready port.
//
// Ports:
//   clk         system clock, all state on the rising edge
//   rst         asynchronous active-low reset
//   en          enable; new words are fetched only while high
//   fifo_empty  FIFO empty flag
//   fifo_data   FIFO read data, valid the cycle after fifo_rd
//   fifo_rd     FIFO read strobe, one pulse per word
//   out_data    current byte
//   out_valid   out_data valid
//   out_ready   downstream accepts the byte when high with out_valid
//   out_last    high with the final byte of each word
//   busy        high whenever the FSM is not idle
//   word_count  words fully transmitted, wraps silently
module fifo_byte_serializer #(
    parameter int DATA_W    = 32,
    parameter int BYTE_W    = 8,
    parameter int MSB_FIRST = 0,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic [CNT_W-1:0]  word_count
);

    localparam int NBYTES = DATA_W / BYTE_W;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        LATCH,
        SEND
    } state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] word;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  sel;
    logic              last_byte;
    logic              can_fetch;
    logic              accept;

    assign last_byte = (idx == LAST_IDX);
    assign can_fetch = en && !fifo_empty;
    assign accept    = (state == SEND) && out_ready;

    // Next state and Moore outputs
    always_comb begin
        state_nxt = state;
        fifo_rd   = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (can_fetch) state_nxt = FETCH;
            end
            FETCH: begin
                fifo_rd   = 1'b1;
                state_nxt = LATCH;
            end
            LATCH: begin
                state_nxt = SEND;
            end
            SEND: begin
                out_valid = 1'b1;
                out_last  = last_byte;
                // Back-to-back words skip IDLE so the steady-state rate is
                // NBYTES+2 cycles per word.
                if (out_ready && last_byte) state_nxt = can_fetch ? FETCH : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Byte lane select; index 0 is the first byte on the wire
    always_comb begin
        sel      = (MSB_FIRST != 0) ? (LAST_IDX - idx) : idx;
        out_data = '0;
        for (int unsigned i = 0; i < NBYTES; i++) begin
            if (sel == IDX_W'(i)) out_data = word[i*BYTE_W +: BYTE_W];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word       <= '0;
            idx        <= '0;
            word_count <= '0;
        end else begin
            if (state == LATCH) begin
                word <= fifo_data;
                idx  <= '0;
            end
            if (accept) begin
                if (last_byte) word_count <= word_count + 1'b1;
                else           idx        <= idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_byte_serializer.sv
// Testbench for fifo_byte_serializer: FIFO model, byte-stream scoreboard,
// vector table, hand-written corner sequences and a randomized stream.
module tb_fifo_byte_serializer;

    localparam int CW = 4;  // narrow counter so the wrap is reached

    logic          clk;
    logic          rst;
    logic          en;
    logic          fifo_empty;
    logic [31:0]   fifo_data;
    logic          fifo_rd;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;
    logic [CW-1:0] word_count;

    // second instance: MSB-first build, default counter width
    logic          en2;
    logic          empty2;
    logic [31:0]   data2;
    logic          rd2;
    logic [7:0]    out_data2;
    logic          out_valid2;
    logic          ready2;
    logic          out_last2;
    logic          busy2;
    logic [15:0]   word_count2;

    fifo_byte_serializer #(.DATA_W(32), .BYTE_W(8), .MSB_FIRST(0), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rd(fifo_rd), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .word_count(word_count)
    );

    fifo_byte_serializer #(.DATA_W(32), .BYTE_W(8), .MSB_FIRST(1), .CNT_W(16)) dut2 (
        .clk(clk), .rst(rst), .en(en2), .fifo_empty(empty2), .fifo_data(data2),
        .fifo_rd(rd2), .out_data(out_data2), .out_valid(out_valid2), .out_ready(ready2),
        .out_last(out_last2), .busy(busy2), .word_count(word_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // ---------------- FIFO model (array + read/write indices) ----------------
    logic [31:0] fmem [0:1023];
    int          push_n = 0;   // written only by the stimulus process
    int          rd_idx = 0;   // written only by the monitor
    logic [31:0] next_data = '0;
    bit          pop_pending = 0;

    assign fifo_empty = (rd_idx == push_n);

    task automatic push(input logic [31:0] w);
        fmem[push_n] = w;
        push_n++;
    endtask

    // read data appears the cycle after the read strobe, garbage otherwise
    always @(posedge clk) fifo_data <= pop_pending ? next_data : 32'($urandom);

    // ---------------- monitor / scoreboard ----------------
    logic [8:0]    exp_q [$];   // {last, byte}
    logic [7:0]    cap_q [$];   // every accepted byte
    int            rd_cycs [$];
    logic [CW-1:0] exp_wc = '0;
    int            cyc = 0, rd_cnt = 0, words_done = 0, last_cyc = 0, rd_cyc = 0;
    bit            lat_wait = 0, prev_v = 0, prev_r = 0, prev_l = 0, prev_rd = 0, prev_ok = 0;
    logic [7:0]    prev_d = '0;
    logic [8:0]    e;

    always @(negedge clk) begin
        #2;
        cyc++;
        if (!rst) begin
            exp_q.delete();
            exp_wc      = '0;
            lat_wait    = 0;
            pop_pending = 0;
            prev_v      = 0;
            prev_rd     = 0;
        end else begin
            if (prev_v && !prev_r) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, prev_d);
                check("hold_last", out_last, prev_l);
            end
            check("word_count", word_count, exp_wc);
            if (lat_wait && out_valid) begin
                check("rd_to_valid", cyc - rd_cyc, 2);
                lat_wait = 0;
            end
            pop_pending = fifo_rd;
            if (fifo_rd) begin
                rd_cnt++;
                rd_cyc   = cyc;
                lat_wait = 1;
                rd_cycs.push_back(cyc);
                check("rd_single_pulse", prev_rd, 0);
                check("rd_allowed", prev_ok, 1);
                if (rd_idx < push_n) begin
                    next_data = fmem[rd_idx];
                    rd_idx++;
                    for (int i = 0; i < 4; i++)
                        exp_q.push_back({i == 3, 8'(next_data >> (8 * i))});
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_byte: got %0h, expected no byte", out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("byte", out_data, e[7:0]);
                    check("last", out_last, e[8]);
                    cap_q.push_back(out_data);
                    if (e[8]) begin
                        words_done++;
                        exp_wc   = exp_wc + 1'b1;
                        last_cyc = cyc;
                    end
                end
            end
            prev_v  = out_valid;
            prev_r  = out_ready;
            prev_d  = out_data;
            prev_l  = out_last;
            prev_rd = fifo_rd;
        end
        prev_ok = en && !fifo_empty;
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [31:0] word;
        logic [7:0]  pat;     // out_ready per SEND cycle, bit 0 first
        int          len;
        logic [7:0]  exp [4];
        int          off;     // cycles from fifo_rd to last accepted byte
    } vec_t;

    vec_t tbl [4];

    task automatic wait_idle(input string name, input int maxc);
        bit ok = 0;
        for (int n = 0; n < maxc; n++) begin
            @(negedge clk);
            #3;
            if (!busy && fifo_empty) begin
                ok = 1;
                break;
            end
        end
        if (!ok) timeout(name);
    endtask

    int base_cap, base_rd, base_w, rdc, nv;
    logic [CW-1:0] base_wc;
    bit ok;
    logic [7:0] b2 [$];
    logic       l2 [$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{32'h04030201, 8'h0F, 4, '{8'h01, 8'h02, 8'h03, 8'h04}, 5};
        tbl[1] = '{32'h04030201, 8'h69, 7, '{8'h01, 8'h02, 8'h03, 8'h04}, 8};
        tbl[2] = '{32'hDEADBEEF, 8'h1E, 5, '{8'hEF, 8'hBE, 8'hAD, 8'hDE}, 6};
        tbl[3] = '{32'h000000FF, 8'h47, 7, '{8'hFF, 8'h00, 8'h00, 8'h00}, 8};

        rst = 1'b0; en = 1'b1; out_ready = 1'b1;
        en2 = 1'b0; empty2 = 1'b1; data2 = 32'h04030201; ready2 = 1'b1;
        push(32'h04030201);

        // reset state with a word waiting and en high
        repeat (2) @(negedge clk);
        #3;
        check("rst_fifo_rd", fifo_rd, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_word_count", word_count, 0);
        check("rst_out_data", out_data, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #3;
        check("release_fifo_rd", fifo_rd, 1);
        wait_idle("release_drain", 50);
        check("release_words", words_done, 1);

        // table: single word with an out_ready pattern
        foreach (tbl[t]) begin
            base_cap = cap_q.size(); base_rd = rd_cnt; base_w = words_done;
            @(negedge clk);
            push(tbl[t].word);
            out_ready = 1'b1;
            ok = 0;
            for (int n = 0; n < 20; n++) begin
                @(negedge clk);
                #3;
                if (fifo_rd) begin
                    ok = 1;
                    break;
                end
            end
            if (!ok) timeout("vec_fetch");
            rdc = cyc;
            @(negedge clk);
            for (int k = 0; k < tbl[t].len; k++) begin
                @(negedge clk);
                out_ready = tbl[t].pat[k];
            end
            @(negedge clk);
            out_ready = 1'b1;
            wait_idle("vec_drain", 50);
            check("vec_nbytes", cap_q.size() - base_cap, 4);
            for (int i = 0; i < 4; i++)
                if (base_cap + i < cap_q.size()) check("vec_byte", cap_q[base_cap+i], tbl[t].exp[i]);
            check("vec_rd_pulses", rd_cnt - base_rd, 1);
            check("vec_words", words_done - base_w, 1);
            check("vec_last_cycle", last_cyc - rdc, tbl[t].off);
        end

        // eight back-to-back words at full rate
        base_cap = cap_q.size(); base_rd = rd_cnt; base_w = words_done; base_wc = exp_wc;
        rd_cycs.delete();
        @(negedge clk);
        for (int i = 1; i <= 8; i++) push(32'(i));
        wait_idle("burst_drain", 200);
        check("burst_rd_pulses", rd_cnt - base_rd, 8);
        check("burst_words", words_done - base_w, 8);
        check("burst_word_count", word_count, CW'(base_wc + 4'd8));
        check("burst_busy", busy, 0);
        for (int i = 1; i < rd_cycs.size(); i++) check("burst_spacing", rd_cycs[i] - rd_cycs[i-1], 6);
        check("burst_nbytes", cap_q.size() - base_cap, 32);
        for (int i = 0; i < 32; i++)
            if (base_cap + i < cap_q.size())
                check("burst_byte", cap_q[base_cap+i], (i % 4 == 0) ? 8'(i / 4 + 1) : 8'h00);

        // en dropped during byte 1 of word 5
        base_rd = rd_cnt; base_w = words_done;
        @(negedge clk);
        for (int i = 0; i < 8; i++) push(32'h1100 + 32'(i));
        ok = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            #3;
            if (words_done - base_w == 4 && out_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) timeout("en_word5");
        @(negedge clk);
        en = 1'b0;
        ok = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            #3;
            if (words_done - base_w == 5) begin
                ok = 1;
                break;
            end
        end
        if (!ok) timeout("en_word5_done");
        nv = 0;
        repeat (8) begin
            @(negedge clk);
            #3;
            if (fifo_rd) nv++;
        end
        check("en_low_no_rd", nv, 0);
        check("en_low_busy", busy, 0);
        check("en_low_rd_pulses", rd_cnt - base_rd, 5);
        @(negedge clk);
        en = 1'b1;
        wait_idle("en_resume", 100);
        check("en_resume_rd_pulses", rd_cnt - base_rd, 8);
        check("en_resume_words", words_done - base_w, 8);

        // asynchronous reset while byte 2 is on the port
        base_cap = cap_q.size(); base_rd = rd_cnt; base_w = words_done;
        @(negedge clk);
        push(32'hA1A2A3A4);
        push(32'hB1B2B3B4);
        ok = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            #3;
            if (cap_q.size() - base_cap == 2) begin
                ok = 1;
                break;
            end
        end
        if (!ok) timeout("arst_byte2");
        #1;
        rst = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_word_count", word_count, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        wait_idle("arst_drain", 50);
        check("arst_nbytes", cap_q.size() - base_cap, 6);
        if (cap_q.size() - base_cap == 6) begin
            check("arst_b0", cap_q[base_cap+2], 8'hB4);
            check("arst_b3", cap_q[base_cap+5], 8'hB1);
        end
        check("arst_rd_pulses", rd_cnt - base_rd, 2);
        check("arst_words", words_done - base_w, 1);

        // randomized stream against the scoreboard
        for (int n = 0; n < 900; n++) begin
            @(negedge clk);
            if (n < 700 && ($urandom % 3) == 0) push($urandom);
            en        = ($urandom % 6) != 0;
            out_ready = ($urandom % 4) != 0;
        end
        @(negedge clk);
        en = 1'b1;
        out_ready = 1'b1;
        wait_idle("rand_drain", 2000);
        check("rand_scoreboard_empty", exp_q.size(), 0);
        check("rand_all_read", rd_idx, push_n);

        // MSB-first build
        @(negedge clk);
        en2 = 1'b1;
        empty2 = 1'b0;
        @(negedge clk);
        empty2 = 1'b1;
        #3;
        check("msb_fifo_rd", rd2, 1);
        nv = 0;
        repeat (8) begin
            @(negedge clk);
            #3;
            if (rd2) nv++;
            if (out_valid2) begin
                b2.push_back(out_data2);
                l2.push_back(out_last2);
            end
        end
        check("msb_rd_extra", nv, 0);
        check("msb_nbytes", b2.size(), 4);
        if (b2.size() == 4) begin
            check("msb_b0", b2[0], 8'h04);
            check("msb_b1", b2[1], 8'h03);
            check("msb_b2", b2[2], 8'h02);
            check("msb_b3", b2[3], 8'h01);
            check("msb_last_early", l2[2], 0);
            check("msb_last", l2[3], 1);
        end
        check("msb_word_count", word_count2, 1);
        check("msb_busy", busy2, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fifo_byte_serializer.md
Name: fifo_byte_serializer

Overview:
Downstream consumer of the 32-bit FIFO buffer. Pops one word at a time through the FIFO's rd/empty/data_out interface and emits it as a stream of bytes on a valid/ready output port, for a byte-wide link (UART/SPI transmitter). Handles FIFO read latency, output back-pressure, word framing and a running word count.

Parameters:
DATA_W, 32, FIFO word width; must be an integer multiple of BYTE_W
BYTE_W, 8, output symbol width
MSB_FIRST, 0, 0 = least-significant byte first, 1 = most-significant byte first
CNT_W, 16, width of word_count

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
en  input  1  enable; new words are fetched only while high
fifo_empty  input  1  FIFO empty flag
fifo_data  input  DATA_W  FIFO data_out; valid the cycle after a sampled fifo_rd
fifo_rd  output  1  FIFO read strobe, one-cycle pulse per word
out_data  output  BYTE_W  current byte
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts byte when high with out_valid
out_last  output  1  high with the final byte of each word
busy  output  1  high in any state other than IDLE
word_count  output  CNT_W  words fully transmitted, wraps to 0 at 2^CNT_W

Behaviour:
- Reset (rst low, asynchronous): state IDLE; fifo_rd, out_valid, out_last, busy = 0; out_data = 0; word_count = 0; shift register and byte index = 0. Any word in progress is discarded. Leaves reset on the first rising edge with rst high.
- NBYTES = DATA_W/BYTE_W; byte index counts 0..NBYTES-1.
- States (Moore outputs):
  - IDLE: en && !fifo_empty -> FETCH; else stay.
  - FETCH: fifo_rd = 1 for exactly this cycle; -> LATCH unconditionally.
  - LATCH: fifo_data is valid; captured into word register at end of cycle; byte index cleared; -> SEND.
  - SEND: out_valid = 1; out_data = byte[index] (index 0 = bits [BYTE_W-1:0] when MSB_FIRST=0, top byte when MSB_FIRST=1); out_last = (index == NBYTES-1).
    - out_ready low: hold; out_data/out_last stable.
    - out_ready high, not last: index+1, stay.
    - out_ready high, last: word_count+1; then en && !fifo_empty -> FETCH, else IDLE.
- Latency: fifo_rd pulse to first out_valid = 2 cycles. Steady-state with out_ready=1: NBYTES+2 cycles per word (6 for defaults).
- fifo_rd never asserted while fifo_empty was high in the deciding cycle; never more than one fifo_rd per word.
- en low mid-word: current word completes fully; no further fetch until en returns high.
- fifo_empty rising during SEND: no effect on current word.
- out_valid never drops before its byte is accepted.
- word_count wrap: all-ones + 1 -> 0, no flag.

Test Plan:
1. Hold rst low 2 cycles with en=1, fifo_empty=0 -> fifo_rd, out_valid, out_last, busy, word_count all 0; release -> fifo_rd on first edge after release.
2. FIFO holds 0x04030201, out_ready=1 -> one fifo_rd pulse; out_data 0x01,0x02,0x03,0x04 on 4 consecutive cycles, out_last only with 0x04; word_count=1; return to IDLE when fifo_empty=1.
3. Same word, out_ready toggled 1,0,0,1,0,1,1 -> each byte held stable while out_ready=0; exactly 4 accepted in order 01..04; no extra fifo_rd.
4. FIFO preloaded with words 1..8, then empty, out_ready=1 -> 32 bytes (01 00 00 00, 02 00 00 00, ...), exactly 8 fifo_rd pulses, 6 cycles per word, word_count=8, busy low afterwards.
5. en dropped during byte 1 of word 5 -> word 5 completes (out_last seen), no fifo_rd until en=1, then word 6 fetched.
6. rst pulsed low while sending byte 2 -> out_valid falls immediately (asynchronous); after release, partial word not resumed, next fifo_rd fetches next FIFO entry. MSB_FIRST=1 build with 0x04030201 -> bytes 04,03,02,01.
